// File: rtl/store_result_monitor.sv
// Self-check monitor on the single-cycle MIPS store bus: decides pass, fail or timeout
// and keeps a circular log of recent stores so a board can report the program result.
module store_result_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd84,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] IGNORE_ADDR    = 32'd80,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned LOG_DEPTH      = 8,
  localparam int unsigned IDX_W         = $clog2(LOG_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memoryWrite,
  input  logic [31:0]      dataAddress,
  input  logic [31:0]      writeData,
  input  logic [IDX_W-1:0] logIndex,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [15:0]      storeCount,
  output logic [31:0]      cycleCount,
  output logic [31:0]      lastAddress,
  output logic [31:0]      lastData,
  output logic [IDX_W:0]   logCount,
  output logic [31:0]      logAddress,
  output logic [31:0]      logData
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [31:0]    TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;
  localparam logic [IDX_W:0] LOG_FULL     = LOG_DEPTH[IDX_W:0];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t           r_state;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;
  logic             r_done;
  logic [15:0]      r_store_count;
  logic [31:0]      r_cycle_count;
  logic [31:0]      r_last_addr;
  logic [31:0]      r_last_data;
  logic [IDX_W:0]   r_log_count;
  logic [IDX_W-1:0] r_wr_ptr;
  logic [31:0]      r_log_addr [LOG_DEPTH];
  logic [31:0]      r_log_data [LOG_DEPTH];

  logic             w_run;
  logic             w_accept;
  logic             w_is_pass;
  logic             w_is_ignore;
  logic             w_timeout_hit;
  state_t           w_state_nxt;

  assign w_run         = (r_state == ST_RUN);
  assign w_accept      = w_run & memoryWrite;
  assign w_is_pass     = (dataAddress == PASS_ADDR) && (writeData == PASS_DATA);
  assign w_is_ignore   = (dataAddress == IGNORE_ADDR);
  assign w_timeout_hit = (r_cycle_count == TIMEOUT_LAST);

  // A decisive store outranks the timeout; an ignored store still lets the timeout fire.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (memoryWrite && w_is_pass) begin
          w_state_nxt = ST_PASS;
        end else if (memoryWrite && !w_is_ignore) begin
          w_state_nxt = ST_FAIL;
        end else if (w_timeout_hit) begin
          w_state_nxt = ST_TIMEOUT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
      r_done        <= 1'b0;
      r_store_count <= 16'd0;
      r_cycle_count <= 32'd0;
      r_last_addr   <= 32'd0;
      r_last_data   <= 32'd0;
      r_log_count   <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pass    <= (w_state_nxt == ST_PASS);
      r_fail    <= (w_state_nxt == ST_FAIL);
      r_timeout <= (w_state_nxt == ST_TIMEOUT);
      r_done    <= (w_state_nxt != ST_RUN);
      if (w_run) begin
        r_cycle_count <= sat_inc32(r_cycle_count);
      end
      if (w_accept) begin
        r_store_count <= sat_inc16(r_store_count);
        r_last_addr   <= dataAddress;
        r_last_data   <= writeData;
        r_wr_ptr      <= r_wr_ptr + IDX_W'(1);
        if (r_log_count != LOG_FULL) begin
          r_log_count <= r_log_count + (IDX_W + 1)'(1);
        end
      end
    end
  end

  // Log storage: cleared on reset so unwritten slots read back as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LOG_DEPTH; i++) begin
        r_log_addr[i] <= 32'd0;
        r_log_data[i] <= 32'd0;
      end
    end else if (w_accept) begin
      r_log_addr[r_wr_ptr] <= dataAddress;
      r_log_data[r_wr_ptr] <= writeData;
    end
  end

  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign storeCount  = r_store_count;
  assign cycleCount  = r_cycle_count;
  assign lastAddress = r_last_addr;
  assign lastData    = r_last_data;
  assign logCount    = r_log_count;
  assign logAddress  = r_log_addr[logIndex];
  assign logData     = r_log_data[logIndex];

endmodule

// File: tb/tb_store_result_monitor.sv
// Bench for store_result_monitor: directed scenarios plus randomized store streams
// checked against a queue-based model of the pass/fail/timeout rules.
module tb_store_result_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memoryWrite = 1'b0;
  logic [31:0] dataAddress = 32'd0;
  logic [31:0] writeData = 32'd0;
  logic [2:0]  logIndex = 3'd0;
  logic        done, pass, fail, timeout;
  logic [15:0] storeCount;
  logic [31:0] cycleCount, lastAddress, lastData, logAddress, logData;
  logic [3:0]  logCount;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  store_result_monitor #(
    .TIMEOUT_CYCLES(20),
    .LOG_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .memoryWrite(memoryWrite),
    .dataAddress(dataAddress), .writeData(writeData), .logIndex(logIndex),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .storeCount(storeCount), .cycleCount(cycleCount),
    .lastAddress(lastAddress), .lastData(lastData), .logCount(logCount),
    .logAddress(logAddress), .logData(logData)
  );

  // Reference model: result state plus the full history of accepted stores.
  localparam int M_RUN = 0, M_PASS = 1, M_FAIL = 2, M_TO = 3;
  int          m_state = M_RUN;
  int unsigned m_cyc = 0;
  int unsigned m_cnt = 0;
  logic [31:0] m_la = 32'd0, m_ld = 32'd0;
  logic [31:0] h_addr[$];
  logic [31:0] h_data[$];

  task automatic model_edge(input logic rst, input logic mw, input logic [31:0] a, input logic [31:0] d);
    if (rst) begin
      m_state = M_RUN; m_cyc = 0; m_cnt = 0; m_la = 32'd0; m_ld = 32'd0;
      h_addr.delete(); h_data.delete();
    end else if (m_state == M_RUN) begin
      if (mw) begin
        h_addr.push_back(a); h_data.push_back(d);
        if (m_cnt < 65535) m_cnt++;
        m_la = a; m_ld = d;
      end
      if (mw && a == 32'd84 && d == 32'd7) m_state = M_PASS;
      else if (mw && a != 32'd80) m_state = M_FAIL;
      else if (m_cyc == 19) m_state = M_TO;
      m_cyc++;
    end
  endtask

  // The slot holds the newest store whose sequence number maps onto it.
  function automatic logic [31:0] exp_slot_addr(input int idx);
    for (int k = h_addr.size() - 1; k >= 0; k--) if (k % 8 == idx) return h_addr[k];
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_slot_data(input int idx);
    for (int k = h_data.size() - 1; k >= 0; k--) if (k % 8 == idx) return h_data[k];
    return 32'd0;
  endfunction

  function automatic logic [3:0] exp_log_count();
    return (h_addr.size() > 8) ? 4'd8 : 4'(h_addr.size());
  endfunction

  task automatic apply(input logic rst, input logic mw, input logic [31:0] a, input logic [31:0] d);
    reset = rst; memoryWrite = mw; dataAddress = a; writeData = d;
    model_edge(rst, mw, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 32'd84, 32'd5);
    apply(1'b1, 1'b1, 32'd84, 32'd5);
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset.done got=%0b exp=0", done); end
    n_checks++; if (pass !== 1'b0) begin n_errors++; $display("FAIL reset.pass got=%0b exp=0", pass); end
    n_checks++; if (fail !== 1'b0) begin n_errors++; $display("FAIL reset.fail got=%0b exp=0", fail); end
    n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL reset.timeout got=%0b exp=0", timeout); end
    n_checks++; if (storeCount !== 16'd0) begin n_errors++; $display("FAIL reset.storeCount got=%0d exp=0", storeCount); end
    n_checks++; if (cycleCount !== 32'd0) begin n_errors++; $display("FAIL reset.cycleCount got=%0d exp=0", cycleCount); end
    n_checks++; if (lastAddress !== 32'd0) begin n_errors++; $display("FAIL reset.lastAddress got=%0d exp=0", lastAddress); end
    n_checks++; if (lastData !== 32'd0) begin n_errors++; $display("FAIL reset.lastData got=%0d exp=0", lastData); end
    n_checks++; if (logCount !== 4'd0) begin n_errors++; $display("FAIL reset.logCount got=%0d exp=0", logCount); end
    for (int i = 0; i < 8; i++) begin
      logIndex = 3'(i);
      apply(1'b1, 1'b0, 32'd0, 32'd0);
      n_checks++;
      if (logAddress !== 32'd0 || logData !== 32'd0) begin
        n_errors++; $display("FAIL reset.slot%0d got=(%0d,%0d) exp=(0,0)", i, logAddress, logData);
      end
    end
  endtask

  task automatic test_pass_sequence();
    apply(1'b1, 1'b0, 32'd0, 32'd0);
    apply(1'b1, 1'b0, 32'd0, 32'd0);
    apply(1'b0, 1'b1, 32'd80, 32'd10);
    apply(1'b0, 1'b1, 32'd80, 32'd3);
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL pass_seq.early_done got=%0b exp=0", done); end
    logIndex = 3'd2;
    apply(1'b0, 1'b1, 32'd84, 32'd7);
    n_checks++; if (pass !== 1'b1) begin n_errors++; $display("FAIL pass_seq.pass got=%0b exp=1", pass); end
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL pass_seq.done got=%0b exp=1", done); end
    n_checks++; if (fail !== 1'b0 || timeout !== 1'b0) begin n_errors++; $display("FAIL pass_seq.onehot got=fail%0b/to%0b exp=0/0", fail, timeout); end
    n_checks++; if (storeCount !== 16'd3) begin n_errors++; $display("FAIL pass_seq.storeCount got=%0d exp=3", storeCount); end
    n_checks++; if (lastAddress !== 32'd84 || lastData !== 32'd7) begin n_errors++; $display("FAIL pass_seq.last got=(%0d,%0d) exp=(84,7)", lastAddress, lastData); end
    n_checks++; if (logCount !== 4'd3) begin n_errors++; $display("FAIL pass_seq.logCount got=%0d exp=3", logCount); end
    n_checks++; if (logAddress !== 32'd84 || logData !== 32'd7) begin n_errors++; $display("FAIL pass_seq.slot2 got=(%0d,%0d) exp=(84,7)", logAddress, logData); end
    n_checks++; if (cycleCount !== 32'd3) begin n_errors++; $display("FAIL pass_seq.cycleCount got=%0d exp=3", cycleCount); end
  endtask

  task automatic test_fail_sticky();
    apply(1'b1, 1'b0, 32'd0, 32'd0);
    apply(1'b0, 1'b1, 32'd84, 32'd5);
    n_checks++; if (fail !== 1'b1 || done !== 1'b1) begin n_errors++; $display("FAIL fail_sticky.fail got=fail%0b/done%0b exp=1/1", fail, done); end
    n_checks++; if (storeCount !== 16'd1) begin n_errors++; $display("FAIL fail_sticky.storeCount got=%0d exp=1", storeCount); end
    apply(1'b0, 1'b1, 32'd84, 32'd7);
    n_checks++; if (pass !== 1'b0 || fail !== 1'b1) begin n_errors++; $display("FAIL fail_sticky.hold got=pass%0b/fail%0b exp=0/1", pass, fail); end
    n_checks++; if (storeCount !== 16'd1 || lastData !== 32'd5) begin n_errors++; $display("FAIL fail_sticky.frozen got=cnt%0d/data%0d exp=1/5", storeCount, lastData); end
    n_checks++; if (cycleCount !== 32'd1) begin n_errors++; $display("FAIL fail_sticky.cycleCount got=%0d exp=1", cycleCount); end
  endtask

  task automatic test_timeout();
    apply(1'b1, 1'b0, 32'd0, 32'd0);
    repeat (19) apply(1'b0, 1'b0, 32'd0, 32'd0);
    n_checks++; if (timeout !== 1'b0 || cycleCount !== 32'd19) begin n_errors++; $display("FAIL timeout.before got=to%0b/cyc%0d exp=0/19", timeout, cycleCount); end
    apply(1'b0, 1'b0, 32'd0, 32'd0);
    n_checks++; if (timeout !== 1'b1 || done !== 1'b1) begin n_errors++; $display("FAIL timeout.fire got=to%0b/done%0b exp=1/1", timeout, done); end
    n_checks++; if (cycleCount !== 32'd20 || storeCount !== 16'd0) begin n_errors++; $display("FAIL timeout.counts got=cyc%0d/st%0d exp=20/0", cycleCount, storeCount); end
    apply(1'b0, 1'b1, 32'd84, 32'd7);
    n_checks++; if (pass !== 1'b0 || timeout !== 1'b1 || storeCount !== 16'd0 || cycleCount !== 32'd20) begin
      n_errors++; $display("FAIL timeout.sticky got=pass%0b/to%0b/st%0d/cyc%0d exp=0/1/0/20", pass, timeout, storeCount, cycleCount);
    end
  endtask

  task automatic test_timeout_race();
    apply(1'b1, 1'b0, 32'd0, 32'd0);
    repeat (19) apply(1'b0, 1'b0, 32'd0, 32'd0);
    apply(1'b0, 1'b1, 32'd84, 32'd7);
    n_checks++; if (pass !== 1'b1 || timeout !== 1'b0) begin n_errors++; $display("FAIL race_pass got=pass%0b/to%0b exp=1/0", pass, timeout); end
    apply(1'b1, 1'b0, 32'd0, 32'd0);
    repeat (19) apply(1'b0, 1'b0, 32'd0, 32'd0);
    apply(1'b0, 1'b1, 32'd80, 32'd1);
    n_checks++; if (timeout !== 1'b1 || storeCount !== 16'd1) begin n_errors++; $display("FAIL race_ignore got=to%0b/st%0d exp=1/1", timeout, storeCount); end
  endtask

  task automatic test_log_wrap();
    apply(1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) apply(1'b0, 1'b1, 32'd80, 32'(i));
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL log_wrap.run got=done%0b exp=0", done); end
    n_checks++; if (logCount !== 4'd8 || storeCount !== 16'd10) begin n_errors++; $display("FAIL log_wrap.counts got=log%0d/st%0d exp=8/10", logCount, storeCount); end
    logIndex = 3'd0; apply(1'b0, 1'b0, 32'd0, 32'd0);
    n_checks++; if (logAddress !== 32'd80 || logData !== 32'd8) begin n_errors++; $display("FAIL log_wrap.slot0 got=(%0d,%0d) exp=(80,8)", logAddress, logData); end
    logIndex = 3'd1; apply(1'b0, 1'b0, 32'd0, 32'd0);
    n_checks++; if (logAddress !== 32'd80 || logData !== 32'd9) begin n_errors++; $display("FAIL log_wrap.slot1 got=(%0d,%0d) exp=(80,9)", logAddress, logData); end
    logIndex = 3'd2; apply(1'b0, 1'b0, 32'd0, 32'd0);
    n_checks++; if (logAddress !== 32'd80 || logData !== 32'd2) begin n_errors++; $display("FAIL log_wrap.slot2 got=(%0d,%0d) exp=(80,2)", logAddress, logData); end
  endtask

  task automatic test_reset_mid();
    apply(1'b1, 1'b0, 32'd0, 32'd0);
    apply(1'b0, 1'b1, 32'd100, 32'd1);
    n_checks++; if (fail !== 1'b1) begin n_errors++; $display("FAIL reset_mid.fail got=%0b exp=1", fail); end
    apply(1'b1, 1'b0, 32'd0, 32'd0);
    n_checks++; if ({done, pass, fail, timeout} !== 4'b0000 || storeCount !== 16'd0 || cycleCount !== 32'd0 ||
                    lastAddress !== 32'd0 || logCount !== 4'd0) begin
      n_errors++; $display("FAIL reset_mid.clear got=flags%b/st%0d/cyc%0d/la%0d/log%0d exp=0000/0/0/0/0",
                           {done, pass, fail, timeout}, storeCount, cycleCount, lastAddress, logCount);
    end
    apply(1'b0, 1'b1, 32'd84, 32'd7);
    n_checks++; if (pass !== 1'b1 || storeCount !== 16'd1) begin n_errors++; $display("FAIL reset_mid.pass got=pass%0b/st%0d exp=1/1", pass, storeCount); end
  endtask

  task automatic test_random();
    logic        mw;
    logic [31:0] a, d;
    int          sel;
    for (int ep = 0; ep < 8; ep++) begin
      apply(1'b1, 1'b0, 32'd0, 32'd0);
      for (int c = 0; c < 26; c++) begin
        mw  = ($urandom % 3) != 0;
        sel = int'($urandom % 10);
        a   = (sel < 7) ? 32'd80 : (sel < 9) ? 32'd84 : $urandom;
        d   = 32'($urandom % 12);
        logIndex = 3'($urandom % 8);
        apply(1'b0, mw, a, d);
        n_checks++;
        if ({pass, fail, timeout, done} !== {m_state == M_PASS, m_state == M_FAIL, m_state == M_TO, m_state != M_RUN}) begin
          n_errors++; $display("FAIL random.flags ep%0d c%0d got=%b exp_state=%0d", ep, c, {pass, fail, timeout, done}, m_state);
        end
        n_checks++;
        if (storeCount !== 16'(m_cnt) || cycleCount !== m_cyc) begin
          n_errors++; $display("FAIL random.counts ep%0d c%0d got=st%0d/cyc%0d exp=st%0d/cyc%0d", ep, c, storeCount, cycleCount, m_cnt, m_cyc);
        end
        n_checks++;
        if (lastAddress !== m_la || lastData !== m_ld) begin
          n_errors++; $display("FAIL random.last ep%0d c%0d got=(%0h,%0h) exp=(%0h,%0h)", ep, c, lastAddress, lastData, m_la, m_ld);
        end
        n_checks++;
        if (logCount !== exp_log_count() || logAddress !== exp_slot_addr(int'(logIndex)) || logData !== exp_slot_data(int'(logIndex))) begin
          n_errors++; $display("FAIL random.log ep%0d c%0d idx%0d got=cnt%0d/(%0h,%0h) exp=cnt%0d/(%0h,%0h)", ep, c, logIndex,
                               logCount, logAddress, logData, exp_log_count(), exp_slot_addr(int'(logIndex)), exp_slot_data(int'(logIndex)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_sequence();
    test_fail_sticky();
    test_timeout();
    test_timeout_race();
    test_log_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
